faxi_rd_burst: RTL

//  AXI4 slave read-burst sequencer: accepts one AR request, walks every beat of the burst, issues
//  per-beat reads to a synchronous 1-cycle-latency memory, returns data on the R channel with RLAST.

---
 rtl/faxi_rd_burst.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/faxi_rd_burst.sv
// faxi_rd_burst: AXI4 slave read-burst sequencer with 1-cycle-latency memory port.
//   faxi_addr     : next beat address for FIXED / INCR / WRAP bursts
//     i_addr, i_size, i_burst, i_len -> o_next_addr
//   faxi_rd_burst : AR accept, per-beat memory read issue, 2-entry R output FIFO
//     i_clk, i_reset            clock, async active-high reset
//     AR: i_axi_arvalid/o_axi_arready, i_axi_arid, i_axi_araddr, i_axi_arlen, i_axi_arsize, i_axi_arburst
//     R : o_axi_rvalid/i_axi_rready, o_axi_rid, o_axi_rdata, o_axi_rresp, o_axi_rlast
//     MEM: o_mem_rd, o_mem_addr, i_mem_rdata (valid the cycle after o_mem_rd)
module faxi_addr #(
    parameter int AW = 32
) (
    input  logic [AW-1:0] i_addr,
    input  logic [2:0]    i_size,
    input  logic [1:0]    i_burst,
    input  logic [7:0]    i_len,
    output logic [AW-1:0] o_next_addr
);
    logic [AW-1:0] step, aligned, incr, wmask;
    always_comb begin
        step        = AW'(1) << i_size;
        aligned     = i_addr & ~(step - AW'(1));
        incr        = aligned + step;
        wmask       = ((AW'(i_len) + AW'(1)) << i_size) - AW'(1);
        o_next_addr = i_burst == 2'b00 ? i_addr :
                      i_burst == 2'b10 ? (aligned & ~wmask) | (incr & wmask) : incr;
    end
endmodule

module faxi_rd_burst #(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int IDW = 4
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic           i_axi_arvalid,
    output logic           o_axi_arready,
    input  logic [IDW-1:0] i_axi_arid,
    input  logic [AW-1:0]  i_axi_araddr,
    input  logic [7:0]     i_axi_arlen,
    input  logic [2:0]     i_axi_arsize,
    input  logic [1:0]     i_axi_arburst,
    output logic           o_axi_rvalid,
    input  logic           i_axi_rready,
    output logic [IDW-1:0] o_axi_rid,
    output logic [DW-1:0]  o_axi_rdata,
    output logic [1:0]     o_axi_rresp,
    output logic           o_axi_rlast,
    output logic           o_mem_rd,
    output logic [AW-1:0]  o_mem_addr,
    input  logic [DW-1:0]  i_mem_rdata
);
    typedef enum logic {IDLE, BURST} state_t;
    localparam logic [2:0] SZ_MAX = 3'($clog2(DW/8));

    state_t         state_q;
    logic [IDW-1:0] id_q;
    logic [AW-1:0]  addr_q, next_addr;
    logic [7:0]     len_q;
    logic [2:0]     size_q;
    logic [1:0]     burst_q, cnt_q, cnt_d;
    logic [8:0]     beats_q;
    logic           err_q, infl_q, infl_last_q, wp_q, rp_q;
    logic [DW-1:0]  fd_q [2];
    logic           fl_q [2];
    logic           ar_hs, r_hs, ar_err, issue;
    logic [2:0]     credit;

    faxi_addr #(.AW(AW)) u_addr (
        .i_addr      (addr_q),
        .i_size      (size_q),
        .i_burst     (burst_q),
        .i_len       (len_q),
        .o_next_addr (next_addr)
    );

    assign o_axi_arready = state_q == IDLE;
    assign ar_hs         = i_axi_arvalid && o_axi_arready;
    assign o_axi_rvalid  = cnt_q != 2'd0;
    assign r_hs          = o_axi_rvalid && i_axi_rready;
    assign o_axi_rdata   = fd_q[rp_q];
    assign o_axi_rlast   = o_axi_rvalid && fl_q[rp_q];
    assign o_axi_rid     = id_q;
    assign o_axi_rresp   = err_q ? 2'b10 : 2'b00;
    assign ar_err        = i_axi_arburst == 2'b11 || i_axi_arsize > SZ_MAX ||
                           (i_axi_arburst == 2'b10 && !(i_axi_arlen inside {8'd1, 8'd3, 8'd7, 8'd15}));
    // Credit counts this cycle's pop as already freed so a held-high rready sustains one beat per cycle;
    // anything issued now lands two edges later, by which point it still fits in the 2-entry FIFO.
    assign credit        = {1'b0, cnt_q} + {2'b0, infl_q} - {2'b0, r_hs};
    assign issue         = state_q == BURST && beats_q != 9'd0 && credit < 3'd2;
    assign o_mem_rd      = issue && !err_q;
    assign o_mem_addr    = addr_q;
    assign cnt_d         = cnt_q + {1'b0, infl_q} - {1'b0, r_hs};

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= IDLE;
            id_q        <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            beats_q     <= '0;
            err_q       <= 1'b0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            wp_q        <= 1'b0;
            rp_q        <= 1'b0;
            cnt_q       <= '0;
            fd_q        <= '{default: '0};
            fl_q        <= '{default: 1'b0};
        end else begin
            if (state_q == IDLE && ar_hs) begin
                state_q <= BURST;
                id_q    <= i_axi_arid;
                addr_q  <= i_axi_araddr;
                len_q   <= i_axi_arlen;
                size_q  <= i_axi_arsize;
                burst_q <= i_axi_arburst;
                beats_q <= {1'b0, i_axi_arlen} + 9'd1;
                err_q   <= ar_err;
            end
            if (issue) begin
                addr_q  <= next_addr;
                beats_q <= beats_q - 9'd1;
            end
            if (state_q == BURST && r_hs && o_axi_rlast)
                state_q <= IDLE;
            // Error beats ride the same one-cycle slot as a memory read but carry zero data.
            infl_q      <= issue;
            infl_last_q <= issue && beats_q == 9'd1;
            if (infl_q) begin
                fd_q[wp_q] <= err_q ? '0 : i_mem_rdata;
                fl_q[wp_q] <= infl_last_q;
                wp_q       <= ~wp_q;
            end
            if (r_hs)
                rp_q <= ~rp_q;
            cnt_q <= cnt_d;
        end
    end
endmodule
